// File: rtl/udp_recv.sv
// MII receive path: nibble-wide Ethernet frame parser.
// Stages: preamble/SFD, MAC header, IPv4 or ARP, UDP header, payload.
// Frames addressed to this station have their UDP payload nibbles written
// to a downstream FIFO. Each frame ends with an ok/err pulse, and valid ARP
// requests raise arp_req.
// Handshake: there is no back-pressure. fifo_wr is a one-cycle write strobe
// with fifo_data valid in the same cycle. The FIFO must accept every strobe.
module udp_recv #(
  parameter int MAX_LEN = 1472
) (
  input  logic        r_clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [3:0]  rx_data,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  output logic [3:0]  fifo_data,
  output logic        fifo_wr,
  output logic [15:0] udp_len,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        arp_req,
  output logic [47:0] arp_src_mac,
  output logic [31:0] arp_src_ip
);
  typedef enum logic [2:0] {SKIP, IDLE, PRE, MAC, IP, UDP, DATA, ARP} state_t;

  localparam logic [15:0] MAX_TOT = 16'(MAX_LEN + 8);
  // Bit-reflected form of the Ethernet residue 32'hC704DD7B, because the CRC
  // register below shifts right (LSB-first).
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_t      state, state_nx;
  logic [11:0] cnt;        // nibble index within the current state
  logic [3:0]  lo;         // previous nibble (low half of the byte being built)
  logic [39:0] sh;         // last five completed bytes, newest in [7:0]
  logic [15:0] csum;       // running one's-complement IP header sum
  logic [31:0] crc;
  logic [16:0] data_cnt;   // payload nibbles written so far
  logic [47:0] sha_q;
  logic [31:0] spa_q;

  logic        wr_nx, ok_nx, err_nx, arp_nx;
  logic [7:0]  cur_byte;
  logic [15:0] cur_word;
  logic [31:0] cur_dw;
  logic [47:0] cur_mac;
  logic [16:0] csum_add;
  logic [15:0] csum_nx;
  logic [31:0] crc_nx;
  logic [16:0] target;
  logic        crc_good;

  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Field views ending with the nibble being sampled this cycle.
  assign cur_byte = {rx_data, lo};
  assign cur_word = {sh[7:0], cur_byte};
  assign cur_dw   = {sh[23:0], cur_byte};
  assign cur_mac  = {sh[39:0], cur_byte};
  assign csum_add = {1'b0, csum} + {1'b0, cur_word};
  assign csum_nx  = csum_add[15:0] + {15'd0, csum_add[16]};
  assign crc_nx   = crc_nibble(crc, rx_data);
  assign target   = {udp_len, 1'b0};
  assign crc_good = (crc == CRC_RESIDUE);

  // State register.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) state <= SKIP;
    else        state <= state_nx;
  end

  // Next-state logic, header filters and end-of-frame result decisions.
  always_comb begin
    state_nx = state;
    wr_nx    = 1'b0;
    ok_nx    = 1'b0;
    err_nx   = 1'b0;
    arp_nx   = 1'b0;
    if (!rx_dv) begin
      state_nx = IDLE;
      if (state == DATA) begin
        if (crc_good && data_cnt == target) ok_nx = 1'b1;
        else                                err_nx = 1'b1;
      end
      if (state == ARP && cnt >= 12'd56 && crc_good) arp_nx = 1'b1;
    end else begin
      case (state)
        SKIP: state_nx = SKIP;
        IDLE: state_nx = (rx_data == 4'h5) ? PRE : SKIP;
        PRE: begin
          if (rx_data == 4'hD && cnt >= 12'd6) state_nx = MAC;
          else if (rx_data != 4'h5)            state_nx = SKIP;
        end
        MAC: begin
          if (cnt == 12'd11 && cur_mac != local_mac && cur_mac != '1) state_nx = SKIP;
          if (cnt == 12'd27) begin
            if (cur_word == 16'h0800)      state_nx = IP;
            else if (cur_word == 16'h0806) state_nx = ARP;
            else                           state_nx = SKIP;
          end
        end
        IP: begin
          if (cnt == 12'd1 && cur_byte != 8'h45)  state_nx = SKIP;
          if (cnt == 12'd19 && cur_byte != 8'd17) state_nx = SKIP;
          if (cnt == 12'd39)
            state_nx = (cur_dw == local_ip && csum_nx == 16'hFFFF) ? UDP : SKIP;
        end
        UDP: begin
          if (cnt == 12'd7 && cur_word != local_port) state_nx = SKIP;
          if (cnt == 12'd11 && (cur_word < 16'd8 || cur_word > MAX_TOT)) state_nx = SKIP;
          if (cnt == 12'd15) state_nx = DATA;
        end
        DATA: wr_nx = (data_cnt != target);
        ARP: begin
          if (cnt == 12'd3  && cur_word != 16'h0001) state_nx = SKIP;
          if (cnt == 12'd7  && cur_word != 16'h0800) state_nx = SKIP;
          if (cnt == 12'd11 && cur_word != 16'h0604) state_nx = SKIP;
          if (cnt == 12'd15 && cur_word != 16'h0001) state_nx = SKIP;
          if (cnt == 12'd55 && cur_dw != local_ip)   state_nx = SKIP;
        end
        default: state_nx = SKIP;
      endcase
    end
  end

  // Datapath: counters, byte assembly, checksums, captures and registered outputs.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      lo          <= '0;
      sh          <= '0;
      csum        <= '0;
      crc         <= '1;
      data_cnt    <= '0;
      sha_q       <= '0;
      spa_q       <= '0;
      fifo_data   <= '0;
      fifo_wr     <= 1'b0;
      udp_len     <= '0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      arp_req     <= 1'b0;
      arp_src_mac <= '0;
      arp_src_ip  <= '0;
    end else begin
      lo <= rx_data;
      if (cnt[0]) sh <= {sh[31:0], cur_byte};

      if (state_nx != state)  cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + 12'd1;

      if (state != IP)                         csum <= '0;
      else if (rx_dv && cnt[1:0] == 2'b11)     csum <= csum_nx;

      // CRC restarts on the SFD and then covers every nibble, FCS included.
      if (state == PRE)                        crc <= '1;
      else if (rx_dv && state inside {MAC, IP, UDP, DATA, ARP}) crc <= crc_nx;

      if (state != DATA)  data_cnt <= '0;
      else if (wr_nx)     data_cnt <= data_cnt + 17'd1;

      if (rx_dv && state == UDP && cnt == 12'd15) udp_len <= sh[23:8] - 16'd8;

      if (rx_dv && state == ARP && cnt == 12'd27) sha_q <= cur_mac;
      if (rx_dv && state == ARP && cnt == 12'd35) spa_q <= cur_dw;

      fifo_wr <= wr_nx;
      if (wr_nx) fifo_data <= rx_data;
      frame_ok  <= ok_nx;
      frame_err <= err_nx;
      arp_req   <= arp_nx;
      if (arp_nx) begin
        arp_src_mac <= sha_q;
        arp_src_ip  <= spa_q;
      end
    end
  end
endmodule
